stack_pointer_unit: RTL and testbench
=====================================

Name: stack_pointer_unit

Overview:
Parametrised successor to the CPU stack pointer. Tracks the stack pointer and the current stack occupancy, and supports either growth direction. Detects overflow and underflow and suppresses the offending operation, so the pointer never leaves its window. Sits in the CPU datapath between decode (push, pop and clear strobes) and the data-memory address mux.

Parameters:
WIDTH, 16, stack pointer and address width in bits.
BASE, 16'hFFFF, empty-stack pointer value (one slot beyond the first usable slot).
DEPTH, 256, maximum number of entries; legal range is 1 to 2**WIDTH-1.
GROW_DOWN, 1, 1 = push decrements the pointer; 0 = push increments it.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising clk edge.
push  input  1  push strobe, one entry per cycle while high.
pop  input  1  pop strobe, one entry per cycle while high.
clear  input  1  synchronous return to the empty stack; does not touch the error flags.
clr_err  input  1  clears the sticky ovf and unf flags.
out  output  WIDTH  current stack pointer, registered.
next_push_addr  output  WIDTH  combinational: out-1 if GROW_DOWN, else out+1. This is the address the next push writes.
depth  output  $clog2(DEPTH+1)  current occupancy, registered.
empty  output  1  combinational, depth==0.
full  output  1  combinational, depth==DEPTH.
err  output  1  registered one-cycle pulse; high the cycle after a rejected operation.
ovf  output  1  sticky: a push was rejected while full.
unf  output  1  sticky: a pop was rejected while empty.

Behaviour:
- Stack model is full-stack: out addresses the top entry. When empty, out==BASE.
- Reset (reset==0 at the edge): out=BASE, depth=0, err=0, ovf=0, unf=0. Reset overrides every other input.
- Priority when reset is inactive: clear > push&pop > push > pop.
- clear: out=BASE, depth=0, err=0. ovf and unf are held.
- push only, not full: out <= next_push_addr; depth <= depth+1.
- push only, full: out and depth unchanged; err=1 next cycle; ovf set.
- pop only, not empty: out <= out+1 if GROW_DOWN, else out-1; depth <= depth-1.
- pop only, empty: out and depth unchanged; err=1 next cycle; unf set.
- push and pop together: out and depth unchanged. This is replace-top semantics. It never errors, even when empty or full.
- clr_err: ovf=0 and unf=0 next cycle. If a rejection occurs in the same cycle, the set wins.
- err is otherwise 0. Back-to-back rejected operations hold err high continuously.
- Arithmetic is modulo 2**WIDTH. BASE plus or minus DEPTH may wrap through 0 or 2**WIDTH-1; depth is the only bound checked.
- Latency: every state change is visible on out and depth one cycle after the strobe edge. There are no wait states, and one operation is accepted per cycle.
- Reset asserted mid-sequence discards all state on that edge.

Test Plan:
1. DEPTH=4, BASE=16'h00FF, GROW_DOWN=1. Pulse reset low, then push for 4 cycles: out goes 00FE, 00FD, 00FC, 00FB; depth=4; full=1; err=0.
2. Continuing from 1, one further push: out stays 00FB, err=1 for exactly one cycle, ovf=1 stays high. Then clr_err: ovf=0.
3. From empty, pop: out=00FF, depth=0, err pulse, unf=1. Then push+pop together while empty: no change, no err.
4. GROW_DOWN=0, BASE=16'h1000. Push 3, pop 1: out goes 1001, 1002, 1003, 1002; depth=2; next_push_addr=1003.
5. With depth=3: clear and push asserted together gives out=BASE, depth=0, and the ovf/unf flags unchanged. A later reset low mid-push-burst gives out=BASE, depth=0, all flags 0.
6. WIDTH=16, BASE=16'h0001, GROW_DOWN=1. Push 3: out goes 0000, FFFF, FFFE (wrap); pop 3 returns to 0001 with empty=1.

Source files
------------

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - CPU stack pointer with occupancy tracking, either growth direction, overflow/underflow guard
module stack_pointer_unit #(
    parameter int                WIDTH     = 16,
    parameter logic [WIDTH-1:0]  BASE      = 16'hFFFF,
    parameter int                DEPTH     = 256,
    parameter bit                GROW_DOWN = 1'b1,
    localparam int               DW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] next_push_addr,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             err,
    output logic             ovf,
    output logic             unf
);

    localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] pop_addr;

    // Push and pop step in opposite directions; wrap is modulo 2**WIDTH by construction.
    assign next_push_addr = GROW_DOWN ? (out - ONE) : (out + ONE);
    assign pop_addr       = GROW_DOWN ? (out + ONE) : (out - ONE);
    assign empty          = (depth == '0);
    assign full           = (depth == DEPTH_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out   <= BASE;
            depth <= '0;
            err   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            err <= 1'b0;
            // Flag clears come first so a same-cycle rejection below overrides them.
            if (clr_err) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (clear) begin
                out   <= BASE;
                depth <= '0;
            end else if (push && pop) begin
                // Replace-top: pointer and occupancy hold, never an error.
                out   <= out;
                depth <= depth;
            end else if (push) begin
                if (full) begin
                    err <= 1'b1;
                    ovf <= 1'b1;
                end else begin
                    out   <= next_push_addr;
                    depth <= depth + DW'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    err <= 1'b1;
                    unf <= 1'b1;
                end else begin
                    out   <= pop_addr;
                    depth <= depth - DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb/tb_stack_pointer_unit.sv - three configurations driven in lockstep against an occupancy-count model
module tb_stack_pointer_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, push, pop, clear, clr_err;
    logic [15:0] o[3];
    logic [15:0] npa[3];
    logic [2:0]  d[3];
    logic        e[3], f[3], er[3], ov[3], un[3];

    stack_pointer_unit #(.WIDTH(16), .BASE(16'h00FF), .DEPTH(4), .GROW_DOWN(1'b1)) u0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear), .clr_err(clr_err),
        .out(o[0]), .next_push_addr(npa[0]), .depth(d[0]), .empty(e[0]), .full(f[0]),
        .err(er[0]), .ovf(ov[0]), .unf(un[0]));

    stack_pointer_unit #(.WIDTH(16), .BASE(16'h1000), .DEPTH(4), .GROW_DOWN(1'b0)) u1 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear), .clr_err(clr_err),
        .out(o[1]), .next_push_addr(npa[1]), .depth(d[1]), .empty(e[1]), .full(f[1]),
        .err(er[1]), .ovf(ov[1]), .unf(un[1]));

    stack_pointer_unit #(.WIDTH(16), .BASE(16'h0001), .DEPTH(4), .GROW_DOWN(1'b1)) u2 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear), .clr_err(clr_err),
        .out(o[2]), .next_push_addr(npa[2]), .depth(d[2]), .empty(e[2]), .full(f[2]),
        .err(er[2]), .ovf(ov[2]), .unf(un[2]));

    localparam int CAP = 4;

    logic [15:0] base_v[3];
    bit          gd_v[3];
    int          m_cnt[3];
    bit          m_err[3], m_ovf[3], m_unf[3];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The pointer is just BASE offset by the occupancy, in the growth direction.
    function automatic logic [15:0] exp_out(input int i);
        logic [15:0] c;
        c = 16'(m_cnt[i]);
        return gd_v[i] ? base_v[i] - c : base_v[i] + c;
    endfunction

    task automatic model_edge(input bit r, input bit pu, input bit po, input bit cl, input bit ce);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                m_cnt[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
            end else begin
                m_err[i] = 0;
                if (ce) begin m_ovf[i] = 0; m_unf[i] = 0; end
                if (cl) m_cnt[i] = 0;
                else if (pu && !po) begin
                    if (m_cnt[i] == CAP) begin m_err[i] = 1; m_ovf[i] = 1; end
                    else m_cnt[i]++;
                end else if (po && !pu) begin
                    if (m_cnt[i] == 0) begin m_err[i] = 1; m_unf[i] = 1; end
                    else m_cnt[i]--;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] eo;
        for (int i = 0; i < 3; i++) begin
            eo = exp_out(i);
            chk($sformatf("u%0d.out", i), o[i], eo);
            chk($sformatf("u%0d.next_push_addr", i), npa[i], gd_v[i] ? eo - 16'd1 : eo + 16'd1);
            chk($sformatf("u%0d.depth", i), 16'(d[i]), 16'(m_cnt[i]));
            chk($sformatf("u%0d.empty", i), 16'(e[i]), 16'(m_cnt[i] == 0));
            chk($sformatf("u%0d.full", i), 16'(f[i]), 16'(m_cnt[i] == CAP));
            chk($sformatf("u%0d.err", i), 16'(er[i]), 16'(m_err[i]));
            chk($sformatf("u%0d.ovf", i), 16'(ov[i]), 16'(m_ovf[i]));
            chk($sformatf("u%0d.unf", i), 16'(un[i]), 16'(m_unf[i]));
        end
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit cl, input bit ce);
        reset = r; push = pu; pop = po; clear = cl; clr_err = ce;
        @(posedge clk);
        model_edge(r, pu, po, cl, ce);
        #1;
        check_all();
    endtask

    logic [15:0] exp_seq[4];

    initial begin
        base_v[0] = 16'h00FF; gd_v[0] = 1'b1;
        base_v[1] = 16'h1000; gd_v[1] = 1'b0;
        base_v[2] = 16'h0001; gd_v[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
        end
        reset = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; clr_err = 1'b0;

        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        chk("reset.out", o[0], 16'h00FF);

        exp_seq[0] = 16'h00FE; exp_seq[1] = 16'h00FD; exp_seq[2] = 16'h00FC; exp_seq[3] = 16'h00FB;
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0, 0, 0);
            chk($sformatf("push%0d.out", k), o[0], exp_seq[k]);
        end
        chk("fill.full", 16'(f[0]), 16'd1);

        step(1, 1, 0, 0, 0);
        chk("ovf.out", o[0], 16'h00FB);
        chk("ovf.err", 16'(er[0]), 16'd1);
        step(1, 1, 0, 0, 0);
        chk("ovf.err_held", 16'(er[0]), 16'd1);
        step(1, 0, 0, 0, 0);
        chk("ovf.err_drop", 16'(er[0]), 16'd0);
        chk("ovf.sticky", 16'(ov[0]), 16'd1);
        step(1, 1, 0, 0, 1);
        chk("ovf.set_beats_clr", 16'(ov[0]), 16'd1);
        step(1, 0, 0, 0, 1);
        chk("clr_err.ovf", 16'(ov[0]), 16'd0);

        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);
        chk("unf.out", o[0], 16'h00FF);
        chk("unf.flag", 16'(un[0]), 16'd1);
        step(1, 1, 1, 0, 0);
        chk("pushpop.empty_err", 16'(er[0]), 16'd0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("pushpop.full_err", 16'(er[0]), 16'd0);

        step(0, 0, 0, 0, 0);
        exp_seq[0] = 16'h1001; exp_seq[1] = 16'h1002; exp_seq[2] = 16'h1003; exp_seq[3] = 16'h1002;
        for (int k = 0; k < 4; k++) begin
            step(1, k < 3, k == 3, 0, 0);
            chk($sformatf("up%0d.out", k), o[1], exp_seq[k]);
        end
        chk("up.depth", 16'(d[1]), 16'd2);
        chk("up.npa", npa[1], 16'h1003);

        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        chk("clear.out", o[1], 16'h1000);
        chk("clear.unf_held", 16'(un[1]), 16'd1);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("midreset.out", o[1], 16'h1000);
        chk("midreset.unf", 16'(un[1]), 16'd0);

        exp_seq[0] = 16'h0000; exp_seq[1] = 16'hFFFF; exp_seq[2] = 16'hFFFE;
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0);
            chk($sformatf("wrap%0d.out", k), o[2], exp_seq[k]);
        end
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0);
        chk("wrap.back", o[2], 16'h0001);
        chk("wrap.empty", 16'(e[2]), 16'd1);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 39) != 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
